// File: rtl/alu_seq_core_if.sv
// Operand/request and result/flag bundle for alu_seq_core.
// The master drives the request side; the slave (the ALU stage) drives results and flags.
interface alu_seq_core_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [3:0]       aluOp;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
    output start, aluOp, srcA, srcB,
    input  busy, done, result, zero, neg, carry, ovf
  );

  modport slave (
    input  start, aluOp, srcA, srcB,
    output busy, done, result, zero, neg, carry, ovf
  );
endinterface

// File: rtl/alu_seq_core.sv
// Sequential ALU stage: single-cycle ops plus an iterative shift-add multiply.
// The multiply path is built only when ALU_SEQ_MUL_EN is defined; otherwise opcode 11 is reserved.
module alu_seq_core #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input logic          CLK,
  input logic          Reset,
  alu_seq_core_if.slave bus
);

  if ((1 << CNT_W) < WIDTH) begin : g_cnt_check
    $error("CNT_W too narrow to count WIDTH multiply iterations");
  end

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpSll   = 4'd5;
  localparam logic [3:0] OpSrl   = 4'd6;
  localparam logic [3:0] OpSra   = 4'd7;
  localparam logic [3:0] OpSlt   = 4'd8;
  localparam logic [3:0] OpPassA = 4'd9;
  localparam logic [3:0] OpPassB = 4'd10;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Single-cycle datapath, purely combinational from the live operands.
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       shamt;

  assign shamt    = bus.srcB[3:0];
  assign add_full = {1'b0, bus.srcA} + {1'b0, bus.srcB};
  assign sub_full = {1'b0, bus.srcA} - {1'b0, bus.srcB};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.aluOp)
      OpAdd: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (bus.srcA[WIDTH-1] == bus.srcB[WIDTH-1]) &&
                  (add_full[WIDTH-1] != bus.srcA[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = ~sub_full[WIDTH];  // no-borrow
        alu_v   = (bus.srcA[WIDTH-1] != bus.srcB[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != bus.srcA[WIDTH-1]);
      end
      OpAnd:   alu_res = bus.srcA & bus.srcB;
      OpOr:    alu_res = bus.srcA | bus.srcB;
      OpXor:   alu_res = bus.srcA ^ bus.srcB;
      OpSll:   alu_res = bus.srcA << shamt;
      OpSrl:   alu_res = bus.srcA >> shamt;
      OpSra:   alu_res = WIDTH'($signed(bus.srcA) >>> shamt);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      OpPassA: alu_res = bus.srcA;
      OpPassB: alu_res = bus.srcB;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OpMul = 4'd11;

  typedef enum logic [0:0] {StIdle, StMult} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_sum;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.aluOp == OpMul) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.srcA};
            mplier_d = bus.srcB;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMult;
          end else begin
            result_d = alu_res;
            carry_d  = alu_c;
            ovf_d    = alu_v;
            done_d   = 1'b1;
          end
        end
      end
      StMult: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = acc_sum[WIDTH-1:0];
          carry_d  = 1'b0;
          ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy = (state_q == StMult);
`else
  always_ff @(posedge CLK) begin
    if (Reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Every op, including opcode 11, completes in one edge.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    if (bus.start) begin
      result_d = alu_res;
      carry_d  = alu_c;
      ovf_d    = alu_v;
      done_d   = 1'b1;
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = (result_q == '0);
  assign bus.neg    = result_q[WIDTH-1];
  assign bus.carry  = carry_q;
  assign bus.ovf    = ovf_q;

endmodule
